// File: rtl/lcd_arb_pkg.sv
// Purpose : shared types and constants for the LCD write-port arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, requester index constants, default sizes
// and the round-robin pointer advance helper.
package lcd_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Requester indices as wired by the system.
    localparam int REQ_ACCESS = 0;
    localparam int REQ_GAME   = 1;
    localparam int REQ_SCORE  = 2;

    // Default geometry.
    localparam int NUM_REQ_DEF = 3;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 255;

    // Round-robin pointer position after an owner releases the port.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_rr_picker.sv
// Purpose : combinational winner selection, preferred requester first, else round-robin.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
//
// Ports:
//   req_vec  - requests competing for the port
//   base_ptr - index where the round-robin scan starts (wraps around)
//   pref_vec - preferred requester; honoured only if one-hot and requesting
//   win_vec  - one-hot winner (0 when nothing requests)
//   win_idx  - binary index of the winner
//   win_vld  - at least one request present
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [IW-1:0]      base_ptr,
    input  logic [NUM_REQ-1:0] pref_vec,
    output logic [NUM_REQ-1:0] win_vec,
    output logic [IW-1:0]      win_idx,
    output logic               win_vld
);

    logic          pref_onehot;
    logic          pref_hit;
    logic          found;
    logic [IW-1:0] scan_idx;

    assign pref_onehot = (pref_vec != '0) &&
                         ((pref_vec & (pref_vec - 1'b1)) == '0);
    assign pref_hit    = pref_onehot && ((pref_vec & req_vec) != '0);
    assign win_vld     = (req_vec != '0);

    always_comb begin
        win_vec  = '0;
        win_idx  = '0;
        found    = 1'b0;
        scan_idx = '0;
        if (pref_hit) begin
            win_vec = pref_vec;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pref_vec[i]) begin
                    win_idx = IW'(i);
                end
            end
        end else begin
            // First requester at or above the base pointer, wrapping around.
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = IW'((int'(base_ptr) + k) % NUM_REQ);
                if (!found && req_vec[scan_idx]) begin
                    found             = 1'b1;
                    win_vec[scan_idx] = 1'b1;
                    win_idx           = scan_idx;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Purpose : shares the LCD driver write port between requesters, granting whole bursts.
// Latency : grant one cycle after req is sampled in IDLE; bytes pass through combinationally.
// Backpressure: wr_ready low stalls the owner; TIMEOUT stalled cycles force a release.
//
// Optional feature macro: LCD_ARB_PREEMPT_EN - when defined, a requesting
// preferred requester (lcd_control) takes over the port at the next byte
// boundary without a GAP cycle.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-low reset
//   lcd_control     - one-hot preferred requester, anything else = no preference
//   req/req_last    - per-requester burst request and last-byte marker
//   req_rs/req_data - per-requester register select and packed bytes
//   wr_valid/wr_rs/wr_data/wr_ready - byte interface to the LCD driver
//   grant           - registered one-hot port owner
//   ack             - pulse to the owner when its byte is accepted
//   timeout_pulse   - pulse in the stalled cycle that triggers a forced release
module lcd_bus_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        lcd_control,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ-1:0]        req_rs,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      wr_valid,
    output logic                      wr_rs,
    output logic [DATA_W-1:0]         wr_data,
    input  logic                      wr_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      timeout_pulse
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = $clog2(TIMEOUT + 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]      stall_q, stall_d;

    logic               xfer_fire;
    logic               g_last;
    logic               stall_limit;
    logic [IW-1:0]      rr_after_owner;

    logic [NUM_REQ-1:0] pick_win;
    logic [IW-1:0]      pick_idx;
    logic               pick_vld;

    // ------------------------------------------------------------------
    // Datapath: everything the driver sees is muxed from the owner index.
    // grant_q is zero outside XFER, so wr_valid and ack are too.
    // ------------------------------------------------------------------
    assign wr_valid   = (grant_q & req) != '0;
    assign wr_rs      = req_rs[gidx_q];
    assign wr_data    = req_data[int'(gidx_q)*DATA_W +: DATA_W];
    assign g_last     = req_last[gidx_q];
    assign xfer_fire  = wr_valid & wr_ready;
    assign ack        = grant_q & {NUM_REQ{xfer_fire}};
    assign grant      = grant_q;

    // stall_q holds the stalls seen so far, so the TIMEOUT-th stalled
    // cycle is the one where it equals TIMEOUT-1.
    assign stall_limit   = (stall_q == SW'(TIMEOUT - 1));
    assign timeout_pulse = (state_q == ST_XFER) && wr_valid && !wr_ready && stall_limit;

    assign rr_after_owner = IW'(rr_next(int'(gidx_q), NUM_REQ));

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_idle_pick (
        .req_vec  (req),
        .base_ptr (rr_ptr_q),
        .pref_vec (lcd_control),
        .win_vec  (pick_win),
        .win_idx  (pick_idx),
        .win_vld  (pick_vld)
    );

`ifdef LCD_ARB_PREEMPT_EN
    logic [NUM_REQ-1:0] pre_req;
    logic [NUM_REQ-1:0] pre_win;
    logic [IW-1:0]      pre_idx;
    logic               pre_vld;
    logic               ctl_onehot;
    logic               pref_other;
    logic               preempt_go;

    // Only requesters other than the owner can take the port over.
    assign pre_req    = req & ~grant_q;
    assign ctl_onehot = (lcd_control != '0) &&
                        ((lcd_control & (lcd_control - 1'b1)) == '0);
    assign pref_other = ctl_onehot && ((lcd_control & pre_req) != '0);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pre_pick (
        .req_vec  (pre_req),
        .base_ptr (rr_ptr_q),
        .pref_vec (lcd_control),
        .win_vec  (pre_win),
        .win_idx  (pre_idx),
        .win_vld  (pre_vld)
    );

    // Byte boundary: the cycle the current byte is accepted, or any cycle
    // where no byte is being offered.
    assign preempt_go = (state_q == ST_XFER) && pref_other && pre_vld &&
                        (xfer_fire || !wr_valid);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        stall_d  = stall_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_XFER;
                    grant_d = pick_win;
                    gidx_d  = pick_idx;
                    stall_d = '0;
                end
            end

            ST_XFER: begin
`ifdef LCD_ARB_PREEMPT_EN
                if (preempt_go) begin
                    // Hand over directly; the preempted owner re-competes later.
                    grant_d  = pre_win;
                    gidx_d   = pre_idx;
                    rr_ptr_d = rr_after_owner;
                    stall_d  = '0;
                end else
`endif
                if (!wr_valid) begin
                    // Owner dropped its request: abort without ack.
                    state_d = ST_GAP;
                    grant_d = '0;
                    stall_d = '0;
                end else if (xfer_fire) begin
                    stall_d = '0;
                    if (g_last) begin
                        state_d = ST_GAP;
                        grant_d = '0;
                    end
                end else if (stall_limit) begin
                    state_d = ST_GAP;
                    grant_d = '0;
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end

            ST_GAP: begin
                // gidx_q still names the released owner here.
                state_d  = ST_IDLE;
                rr_ptr_d = rr_after_owner;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                stall_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Purpose : randomized scoreboard bench for lcd_bus_arbiter (default build, no preemption).
// Latency : checks grant one cycle after request, ack in the accepting cycle.
// Backpressure: wr_ready is randomized, held low for timeout cases.
module tb_lcd_bus_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int TO = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    lcd_control;
    logic [N-1:0]    req;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_rs;
    logic [N*DW-1:0] req_data;
    logic            wr_valid;
    logic            wr_rs;
    logic [DW-1:0]   wr_data;
    logic            wr_ready;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;
    logic            timeout_pulse;

    lcd_bus_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lcd_control   (lcd_control),
        .req           (req),
        .req_last      (req_last),
        .req_rs        (req_rs),
        .req_data      (req_data),
        .wr_valid      (wr_valid),
        .wr_rs         (wr_rs),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .grant         (grant),
        .ack           (ack),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- requester agents + scoreboard queues ----------------
    logic [8:0] bytes [N][8];
    int         len   [N];
    int         pos   [N];
    bit         active[N];
    bit         abort_req[N];
    logic [8:0] exp_q [N][$];

    logic [N-1:0] ack_prev;
    bit           gen_en;
    int           ready_mode;   // 0 random, 1 forced low
    int           low_run;
    logic         rst_drive;
    int           to_seen;
    logic [2:0]   pc_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b000, 3'b111, 3'b110};

    task automatic start_burst(input int i, input int l);
        len[i]    = l;
        pos[i]    = 0;
        active[i] = 1'b1;
        for (int b = 0; b < l; b++) begin
            bytes[i][b] = 9'($urandom);
            exp_q[i].push_back(bytes[i][b]);
        end
    endtask

    task automatic clear_agents();
        for (int i = 0; i < N; i++) begin
            active[i]    = 1'b0;
            abort_req[i] = 1'b0;
            pos[i]       = 0;
            len[i]       = 0;
            exp_q[i].delete();
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req[i]                = active[i];
            req_rs[i]             = bytes[i][pos[i]][8];
            req_data[i*DW +: DW]  = bytes[i][pos[i]][7:0];
            req_last[i]           = active[i] && (pos[i] == len[i] - 1);
        end
    endtask

    // One cycle of stimulus, applied at the falling edge.
    task automatic step();
        @(negedge clk);
        rst = rst_drive;
        if (!rst_drive) begin
            clear_agents();
        end
        for (int i = 0; i < N; i++) begin
            if (active[i] && ack_prev[i]) begin
                pos[i]++;
                if (pos[i] == len[i]) active[i] = 1'b0;
            end
            if (abort_req[i]) begin
                active[i]    = 1'b0;
                abort_req[i] = 1'b0;
                exp_q[i].delete();
            end
            if (gen_en && !active[i] && ($urandom_range(0, 3) == 0)) begin
                start_burst(i, int'($urandom_range(1, 4)));
            end
        end
        if (gen_en && ($urandom_range(0, 7) == 0)) begin
            lcd_control = pc_tab[$urandom_range(0, 7)];
        end
        if (ready_mode == 1) begin
            wr_ready = 1'b0;
        end else if (low_run >= 2) begin
            wr_ready = 1'b1;
        end else begin
            wr_ready = ($urandom_range(0, 3) != 0);
        end
        low_run = wr_ready ? 0 : low_run + 1;
        drive_inputs();
    endtask

    // ---------------- reference model (burst-level arbitration rules) ----------------
    int           m_owner = -1;
    bit           m_gap   = 1'b0;
    int           m_last  = 0;
    int           m_ptr   = 0;
    int           m_stall = 0;
    logic [N-1:0] exp_grant = '0;
    logic         exp_valid = 1'b0;
    logic [N-1:0] exp_ack   = '0;
    logic         exp_to    = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] pc, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (pc == (N'(1) << i) && r[i]) return i;
        end
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic end_burst();
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = 1'b1;
        m_stall = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst !== 1'b1) begin
                m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_stall = 0;
                exp_grant = '0; exp_valid = 1'b0; exp_ack = '0; exp_to = 1'b0;
            end else begin
                exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
                exp_valid = (m_owner >= 0) && req[m_owner];
                exp_ack   = (exp_valid && wr_ready) ? exp_grant : '0;
                exp_to    = 1'b0;
                if (m_gap) begin
                    m_gap = 1'b0;
                    m_ptr = (m_last + 1) % N;
                end else if (m_owner < 0) begin
                    if (req != '0) begin
                        m_owner = pick(req, lcd_control, m_ptr);
                        m_stall = 0;
                    end
                end else if (!req[m_owner]) begin
                    end_burst();
                end else if (wr_ready) begin
                    m_stall = 0;
                    if (req_last[m_owner]) end_burst();
                end else begin
                    m_stall++;
                    if (m_stall == TO) begin
                        exp_to = 1'b1;
                        end_burst();
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        ack_prev = '0;
        forever begin
            int gi;
            @(negedge clk);
            #2;
            check("grant", grant, exp_grant);
            check("wr_valid", wr_valid, exp_valid);
            check("ack", ack, exp_ack);
            check("timeout_pulse", timeout_pulse, exp_to);
            if (timeout_pulse === 1'b1) to_seen++;
            if (rst === 1'b1 && wr_valid === 1'b1 && wr_ready === 1'b1) begin
                gi = -1;
                for (int i = 0; i < N; i++) begin
                    if (grant[i] === 1'b1 && gi < 0) gi = i;
                end
                if (gi < 0) begin
                    check("byte_owner", grant, exp_grant);
                end else if (exp_q[gi].size() == 0) begin
                    check("byte_unexpected", {wr_rs, wr_data}, 32'hFFFF_FFFF);
                end else begin
                    check("byte", {wr_rs, wr_data}, exp_q[gi].pop_front());
                end
            end
            ack_prev = ack;
        end
    end

    // ---------------- directed sequence + random traffic ----------------
    initial begin
        bit seen;
        rst = 1'b0; rst_drive = 1'b0;
        lcd_control = '0; req = '0; req_last = '0; req_rs = '0; req_data = '0;
        wr_ready = 1'b1; ready_mode = 0; low_run = 0; gen_en = 1'b0; to_seen = 0;
        for (int i = 0; i < N; i++) for (int b = 0; b < 8; b++) bytes[i][b] = '0;
        clear_agents();

        repeat (3) step();
        rst_drive = 1'b1;
        repeat (10) step();            // idle with no requests

        // Single burst from requester 0.
        start_burst(0, 3);
        bytes[0][0] = 9'h141; bytes[0][1] = 9'h142; bytes[0][2] = 9'h143;
        exp_q[0].delete();
        for (int b = 0; b < 3; b++) exp_q[0].push_back(bytes[0][b]);
        ready_mode = 0; low_run = 2;
        repeat (10) step();

        // Randomized traffic with preference changes.
        gen_en = 1'b1;
        repeat (1500) step();
        gen_en = 1'b0;
        lcd_control = '0;
        begin
            int budget = 300;
            while ((active[0] || active[1] || active[2]) && budget > 0) begin
                step();
                budget--;
            end
            check("drain_done", int'(active[0] || active[1] || active[2]), 0);
        end
        repeat (4) step();
        check("scoreboard_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);

        // Timeout: owner stalled by wr_ready low.
        to_seen = 0;
        start_burst(0, 2);
        ready_mode = 1;
        repeat (12) step();
        check("timeout_seen", int'(to_seen >= 1), 1);
        ready_mode = 0;
        repeat (15) step();

        // Abort mid-burst.
        start_burst(1, 4);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            if (pos[1] >= 1) seen = 1'b1;
        end
        check("abort_progress", seen, 1);
        abort_req[1] = 1'b1;
        repeat (8) step();

        // Asynchronous reset during XFER.
        start_burst(2, 4);
        ready_mode = 1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            #1;
            if (grant === 3'b100) seen = 1'b1;
        end
        check("rst_burst_granted", seen, 1);
        @(negedge clk);
        rst = 1'b0; rst_drive = 1'b0;
        #1;
        check("rst_mid_grant", grant, 0);
        check("rst_mid_valid", wr_valid, 0);
        check("rst_mid_ack", ack, 0);
        clear_agents();
        drive_inputs();
        ready_mode = 0;
        repeat (2) step();
        rst_drive = 1'b1;
        start_burst(1, 2);
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
